// File: rtl/clk_div_gen_pkg.sv
// rtl/clk_div_gen_pkg.sv - shared types and helpers for the clock divider
package clk_div_gen_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

    // High phase length: ceil(R/2), so odd ratios get the extra cycle high
    function automatic int unsigned high_len(input int unsigned r);
        return r - (r >> 1);
    endfunction

    // Low phase length: floor(R/2); zero only for R=1
    function automatic int unsigned low_len(input int unsigned r);
        return r >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: FSM, phase counter and registered outputs
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [RATIO_W-1:0] ratio_i,
    input  logic               sync_i,
    output logic               div_clk_o,
    output logic               tick_o,
    output logic               ratio_ack_o
);

    chan_state_e        state_q;
    logic [RATIO_W-1:0] cnt_q;
    logic [RATIO_W-1:0] act_q;
    logic               div_clk_q;
    logic               tick_q;
    logic               ack_q;

    logic [RATIO_W-1:0] h_len;
    logic [RATIO_W-1:0] l_len;
    logic               high_done;
    logic               boundary;
    logic               start_ok;

    // Phase lengths come from the latched ratio so mid-period edits cannot disturb the current period
    always_comb begin
        h_len     = RATIO_W'(high_len(32'(act_q)));
        l_len     = RATIO_W'(low_len(32'(act_q)));
        high_done = (state_q == ST_HIGH) && (cnt_q == h_len - RATIO_W'(1));
        boundary  = (high_done && (l_len == '0)) ||
                    ((state_q == ST_LOW) && (cnt_q == l_len - RATIO_W'(1)));
        start_ok  = en_i && (ratio_i != '0);
    end

    // Channel FSM; every output is a flop so the divided clock is glitch-free
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            act_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            if (sync_i) begin
                // Sync restarts in phase, truncating whatever period was in flight
                cnt_q <= '0;
                if (start_ok) begin
                    state_q   <= ST_HIGH;
                    act_q     <= ratio_i;
                    div_clk_q <= 1'b1;
                    tick_q    <= 1'b1;
                    ack_q     <= (state_q == ST_OFF) || (ratio_i != act_q);
                end else begin
                    state_q   <= ST_OFF;
                    div_clk_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_OFF: begin
                        cnt_q <= '0;
                        if (start_ok) begin
                            state_q   <= ST_HIGH;
                            act_q     <= ratio_i;
                            div_clk_q <= 1'b1;
                            tick_q    <= 1'b1;
                            ack_q     <= 1'b1;
                        end
                    end
                    ST_HIGH, ST_LOW: begin
                        if (boundary) begin
                            cnt_q <= '0;
                            if (start_ok) begin
                                state_q   <= ST_HIGH;
                                act_q     <= ratio_i;
                                div_clk_q <= 1'b1;
                                tick_q    <= 1'b1;
                                ack_q     <= (ratio_i != act_q);
                            end else begin
                                state_q   <= ST_OFF;
                                div_clk_q <= 1'b0;
                            end
                        end else if (high_done) begin
                            state_q   <= ST_LOW;
                            cnt_q     <= '0;
                            div_clk_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + RATIO_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= ST_OFF;
                        cnt_q     <= '0;
                        div_clk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign div_clk_o   = div_clk_q;
    assign tick_o      = tick_q;
    assign ratio_ack_o = ack_q;

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel divided clocks and clock-enable ticks
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RATIO_W = 8
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_clk_en,
    input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
    input  logic                      i_sync,
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_ratio_ack
);

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            clk_div_chan #(
                .RATIO_W (RATIO_W)
            ) u_chan (
                .clk_i       (i_ref_clk),
                .rst_i       (i_rst),
                .en_i        (i_clk_en[c]),
                .ratio_i     (i_div_ratio[c*RATIO_W +: RATIO_W]),
                .sync_i      (i_sync),
                .div_clk_o   (o_div_clk[c]),
                .tick_o      (o_tick[c]),
                .ratio_ack_o (o_ratio_ack[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
module tb_clk_div_gen;

    localparam int NUM_CH  = 4;
    localparam int RATIO_W = 8;

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         clk_en;
    logic [NUM_CH*RATIO_W-1:0] div_ratio;
    logic                      sync;
    logic [NUM_CH-1:0]         div_clk;
    logic [NUM_CH-1:0]         tick;
    logic [NUM_CH-1:0]         ratio_ack;

    int checks;
    int errors;

    clk_div_gen #(
        .NUM_CH  (NUM_CH),
        .RATIO_W (RATIO_W)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .i_sync      (sync),
        .o_div_clk   (div_clk),
        .o_tick      (tick),
        .o_ratio_ack (ratio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        sync      = 1'b0;
        clk_en    = '0;
        div_ratio = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({div_clk, tick, ratio_ack} !== 12'h000) begin
            errors++;
            $display("FAIL reset: got div=%b tick=%b ack=%b, expected all 0", div_clk, tick, ratio_ack);
        end
        step();
        checks++;
        if ({div_clk, tick, ratio_ack} !== 12'h000) begin
            errors++;
            $display("FAIL idle_after_reset: got div=%b tick=%b ack=%b, expected all 0", div_clk, tick, ratio_ack);
        end
    endtask

    // Run ch0 alone at ratio r for n cycles and check against the ceil/floor split
    task automatic test_single(input string name, input int r, input int n);
        logic [3:0] exp_div, exp_tick, exp_ack;
        int h;
        apply_reset();
        h = r - r / 2;
        div_ratio[7:0] = 8'(r);
        clk_en         = 4'b0001;
        for (int i = 0; i < n; i++) begin
            step();
            exp_div  = (r != 0 && (i % (r == 0 ? 1 : r)) < h) ? 4'b0001 : 4'b0000;
            exp_tick = (r != 0 && (i % (r == 0 ? 1 : r)) == 0) ? 4'b0001 : 4'b0000;
            exp_ack  = (r != 0 && i == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if ({div_clk, tick, ratio_ack} !== {exp_div, exp_tick, exp_ack}) begin
                errors++;
                $display("FAIL %s cycle %0d: got div=%b tick=%b ack=%b, expected div=%b tick=%b ack=%b",
                         name, i, div_clk, tick, ratio_ack, exp_div, exp_tick, exp_ack);
            end
        end
    endtask

    task automatic test_ratio_change();
        logic exp_div, exp_tick, exp_ack;
        int j;
        apply_reset();
        div_ratio[7:0] = 8'd4;
        clk_en         = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i < 4) begin
                exp_div  = (i < 2);
                exp_tick = (i == 0);
                exp_ack  = (i == 0);
            end else begin
                j        = (i - 4) % 6;
                exp_div  = (j < 3);
                exp_tick = (j == 0);
                exp_ack  = (i == 4);
            end
            checks++;
            if ({div_clk[0], tick[0], ratio_ack[0]} !== {exp_div, exp_tick, exp_ack}) begin
                errors++;
                $display("FAIL ratio_change cycle %0d: got div/tick/ack=%b%b%b, expected %b%b%b",
                         i, div_clk[0], tick[0], ratio_ack[0], exp_div, exp_tick, exp_ack);
            end
            if (i == 1) div_ratio[7:0] = 8'd6;
        end
    endtask

    task automatic test_disable();
        logic exp_div, exp_tick;
        apply_reset();
        div_ratio[7:0] = 8'd6;
        clk_en         = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_div  = (i < 3);
            exp_tick = (i == 0);
            checks++;
            if ({div_clk[0], tick[0]} !== {exp_div, exp_tick}) begin
                errors++;
                $display("FAIL disable cycle %0d: got div=%b tick=%b, expected div=%b tick=%b",
                         i, div_clk[0], tick[0], exp_div, exp_tick);
            end
            if (i == 1) clk_en = 4'b0000;
        end
        clk_en = 4'b0001;
        step();
        checks++;
        if ({div_clk[0], tick[0], ratio_ack[0]} !== 3'b111) begin
            errors++;
            $display("FAIL reenable: got div/tick/ack=%b%b%b, expected 111",
                     div_clk[0], tick[0], ratio_ack[0]);
        end
    endtask

    task automatic test_sync();
        int r [3];
        logic [3:0] exp_div, exp_tick;
        r[0] = 3;
        r[1] = 7;
        r[2] = 4;
        apply_reset();
        div_ratio = {8'd5, 8'd4, 8'd7, 8'd3};
        clk_en    = 4'b0001;
        step();
        clk_en = 4'b0011;
        step();
        step();
        clk_en = 4'b0111;
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (ratio_ack !== 4'b0000) begin
            errors++;
            $display("FAIL sync_ack: got ack=%b, expected 0000", ratio_ack);
        end
        for (int i = 0; i < 21; i++) begin
            if (i > 0) step();
            exp_div  = '0;
            exp_tick = '0;
            for (int c = 0; c < 3; c++) begin
                exp_div[c]  = ((i % r[c]) < (r[c] - r[c] / 2));
                exp_tick[c] = ((i % r[c]) == 0);
            end
            checks++;
            if ({div_clk, tick} !== {exp_div, exp_tick}) begin
                errors++;
                $display("FAIL sync cycle %0d: got div=%b tick=%b, expected div=%b tick=%b",
                         i, div_clk, tick, exp_div, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        div_ratio = {8'd4, 8'd4, 8'd4, 8'd4};
        clk_en    = 4'b1111;
        step();
        checks++;
        if (div_clk !== 4'b1111) begin
            errors++;
            $display("FAIL pre_reset_high: got div=%b, expected 1111", div_clk);
        end
        rst  = 1'b1;
        sync = 1'b1;
        step();
        checks++;
        if ({div_clk, tick, ratio_ack} !== 12'h000) begin
            errors++;
            $display("FAIL reset_with_sync: got div=%b tick=%b ack=%b, expected all 0", div_clk, tick, ratio_ack);
        end
        sync = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({div_clk, tick, ratio_ack} !== 12'hfff) begin
            errors++;
            $display("FAIL reset_release: got div=%b tick=%b ack=%b, expected 1111/1111/1111",
                     div_clk, tick, ratio_ack);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        sync      = 1'b0;
        clk_en    = '0;
        div_ratio = '0;
        test_reset();
        test_single("r4", 4, 12);
        test_single("r5", 5, 10);
        test_single("r1", 1, 5);
        test_single("r0", 0, 5);
        test_ratio_change();
        test_disable();
        test_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
